// File: rtl/score_keeper.sv
// score_keeper: two-player packed-BCD scoreboard with edge-detected point inputs.
// Ports: clk, reset_n (sync, active-low), score_in[1:0] (level point requests),
//        new_game (sync clear), score0/score1 (4*NDIG packed BCD, units in [3:0]),
//        point_strobe[1:0] (score changed), game_over, winner (01 P0, 10 P1, 11 tie).
module score_keeper #(
    parameter int NDIG      = 2,
    parameter int WIN_SCORE = 11,
    parameter bit SATURATE  = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        score_in,
    input  logic              new_game,
    output logic [4*NDIG-1:0] score0,
    output logic [4*NDIG-1:0] score1,
    output logic [1:0]        point_strobe,
    output logic              game_over,
    output logic [1:0]        winner
);

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam int W = 4*NDIG;

    // Decimal win threshold converted once to the packed-BCD score format.
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int d = 0; d < NDIG; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (v[4*d +: 4] != 4'd9) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    // Ripple +1 through the digits; all-nines naturally wraps to zero.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (c) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);
    localparam bit           WIN_EN  = (WIN_SCORE != 0);

    state_t       state;
    logic [1:0]   prev;
    logic [1:0]   rise;
    logic [1:0]   upd;
    logic [1:0]   hit;
    logic [W-1:0] next0;
    logic [W-1:0] next1;

    always_comb begin
        rise  = score_in & ~prev;
        next0 = bcd_inc(score0);
        next1 = bcd_inc(score1);
        // In saturating mode an all-nines score is not a change at all.
        upd[0] = rise[0] && !(SATURATE && all_nines(score0));
        upd[1] = rise[1] && !(SATURATE && all_nines(score1));
        hit[0] = WIN_EN && upd[0] && (next0 == WIN_BCD);
        hit[1] = WIN_EN && upd[1] && (next1 == WIN_BCD);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev         <= score_in;
            score0       <= '0;
            score1       <= '0;
            point_strobe <= 2'b00;
            game_over    <= 1'b0;
            winner       <= 2'b00;
            state        <= PLAY;
        end else begin
            prev         <= score_in;
            point_strobe <= 2'b00;
            if (new_game) begin
                score0    <= '0;
                score1    <= '0;
                game_over <= 1'b0;
                winner    <= 2'b00;
                state     <= PLAY;
            end else if (state == PLAY) begin
                if (upd[0]) begin
                    score0          <= next0;
                    point_strobe[0] <= 1'b1;
                end
                if (upd[1]) begin
                    score1          <= next1;
                    point_strobe[1] <= 1'b1;
                end
                if (|hit) begin
                    state     <= OVER;
                    game_over <= 1'b1;
                    winner    <= hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: default game, wrap and saturate variants.
// Three instances share stimulus; each check is an immediate assertion.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] score_in;
    logic       new_game;

    logic [7:0] d_s0, d_s1, w_s0, w_s1, s_s0, s_s1;
    logic [1:0] d_pst, w_pst, s_pst, d_win, w_win, s_win;
    logic       d_go, w_go, s_go;

    int checks = 0;
    int errors = 0;
    int cnt0;
    int cnt1;

    always #5 clk = ~clk;

    score_keeper #(.NDIG(2), .WIN_SCORE(11), .SATURATE(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .score_in(score_in),
        .new_game(new_game), .score0(d_s0), .score1(d_s1),
        .point_strobe(d_pst), .game_over(d_go), .winner(d_win)
    );

    score_keeper #(.NDIG(2), .WIN_SCORE(0), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset_n(reset_n), .score_in(score_in),
        .new_game(new_game), .score0(w_s0), .score1(w_s1),
        .point_strobe(w_pst), .game_over(w_go), .winner(w_win)
    );

    score_keeper #(.NDIG(2), .WIN_SCORE(0), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .score_in(score_in),
        .new_game(new_game), .score0(s_s0), .score1(s_s1),
        .point_strobe(s_pst), .game_over(s_go), .winner(s_win)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cnt0 += int'(d_pst[0]);
        cnt1 += int'(d_pst[1]);
    endtask

    task automatic pulse(input logic [1:0] b);
        score_in = b;
        tick();
        score_in = 2'b00;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s0"}, 32'(d_s0), 32'h0);
        check({tag, "_s1"}, 32'(d_s1), 32'h0);
        check({tag, "_go"}, 32'(d_go), 32'h0);
        check({tag, "_win"}, 32'(d_win), 32'h0);
    endtask

    initial begin
        reset_n  = 1'b0;
        score_in = 2'b00;
        new_game = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        tick();
        tick();
        check_zero("reset");
        check("reset_pst", 32'(d_pst), 32'h0);
        reset_n = 1'b1;
        tick();

        // Nine P0 points, then the tenth carries into the tens digit.
        cnt0 = 0;
        for (int i = 0; i < 9; i++) pulse(2'b01);
        check("p0_nine", 32'(d_s0), 32'h09);
        check("p0_nine_strb", 32'(cnt0), 32'd9);
        pulse(2'b01);
        check("p0_ten", 32'(d_s0), 32'h10);
        check("p0_ten_strb", 32'(cnt0), 32'd10);

        // Holding P1 high is one point only.
        cnt1 = 0;
        score_in = 2'b10;
        for (int i = 0; i < 20; i++) tick();
        score_in = 2'b00;
        tick();
        check("p1_hold", 32'(d_s1), 32'h01);
        check("p1_hold_strb", 32'(cnt1), 32'd1);

        // new_game clears; a same-cycle edge is not counted.
        new_game = 1'b1;
        tick();
        check_zero("ng");
        score_in = 2'b01;
        tick();
        check("ng_prio_s0", 32'(d_s0), 32'h0);
        check("ng_prio_pst", 32'(d_pst), 32'h0);
        new_game = 1'b0;
        score_in = 2'b00;
        tick();
        check("ng_prio_after", 32'(d_s0), 32'h0);

        // Both players together: tie at 11.
        for (int i = 0; i < 10; i++) pulse(2'b11);
        check("tie10_s0", 32'(d_s0), 32'h10);
        check("tie10_go", 32'(d_go), 32'h0);
        pulse(2'b11);
        check("tie_s0", 32'(d_s0), 32'h11);
        check("tie_s1", 32'(d_s1), 32'h11);
        check("tie_go", 32'(d_go), 32'h1);
        check("tie_win", 32'(d_win), 32'h3);
        cnt0 = 0;
        cnt1 = 0;
        pulse(2'b11);
        check("over_s0", 32'(d_s0), 32'h11);
        check("over_s1", 32'(d_s1), 32'h11);
        check("over_strb", 32'(cnt0 + cnt1), 32'd0);

        // Leave OVER, P1 wins alone.
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check_zero("ng_over");
        for (int i = 0; i < 10; i++) pulse(2'b10);
        check("p1_10_go", 32'(d_go), 32'h0);
        pulse(2'b10);
        check("p1win_s1", 32'(d_s1), 32'h11);
        check("p1win_s0", 32'(d_s0), 32'h0);
        check("p1win_go", 32'(d_go), 32'h1);
        check("p1win_win", 32'(d_win), 32'h2);

        // Reset while OVER.
        reset_n = 1'b0;
        tick();
        check_zero("rst_over");
        reset_n = 1'b1;
        tick();

        // Reset mid-game with P0 held high.
        for (int i = 0; i < 3; i++) pulse(2'b01);
        score_in = 2'b01;
        tick();
        check("mid_s0", 32'(d_s0), 32'h04);
        reset_n = 1'b0;
        tick();
        check_zero("rst_mid");
        check("rst_mid_pst", 32'(d_pst), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rel_held_s0", 32'(d_s0), 32'h0);
        check("rel_held_pst", 32'(d_pst), 32'h0);
        score_in = 2'b00;
        tick();
        score_in = 2'b01;
        tick();
        check("rel_toggle_s0", 32'(d_s0), 32'h01);
        score_in = 2'b00;
        tick();

        // Wrap versus saturate, win detection disabled.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 99; i++) pulse(2'b01);
        check("wrap99", 32'(w_s0), 32'h99);
        check("sat99", 32'(s_s0), 32'h99);
        check("nowin_go", 32'(w_go), 32'h0);
        score_in = 2'b01;
        tick();
        check("wrap00", 32'(w_s0), 32'h00);
        check("wrap_strb", 32'(w_pst), 32'h1);
        check("sat_hold", 32'(s_s0), 32'h99);
        check("sat_strb", 32'(s_pst), 32'h0);
        score_in = 2'b00;
        tick();
        pulse(2'b01);
        check("wrap01", 32'(w_s0), 32'h01);
        check("sat_hold2", 32'(s_s0), 32'h99);
        check("sat_go", 32'(s_go), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
